// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: shared header layout and FSM state encoding for the SPI register bridge
package spi_reg_bridge_pkg;
  localparam int HDR_W  = 8;
  localparam int RW_BIT = 7;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes SPI pins into clk and turns sck transitions into one-cycle rise/fall events
// Ports: clk, rst (async, active-high); sck_i/cs_n_i/mosi_i raw pins;
//        sck_rise_o/sck_fall_o one-clk events; cs_n_o/mosi_o synchronized levels.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic mosi_i,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic cs_n_o,
  output logic mosi_o
);
  logic [2:0] sck_q;
  logic [1:0] cs_q, mosi_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], sck_i};
      cs_q   <= {cs_q[0], cs_n_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end
  // mosi has the same two-stage latency as sck_q[1], so it is aligned with the rise event
  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign cs_n_o     = cs_q[1];
  assign mosi_o     = mosi_q[1];
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns header+data frames into register-bus read/write strobes
// Ports: clk, rst (async, active-high); spiSck/spiCs_n/spiMosi from host, spiMiso to host;
//        rdData read-back for aBus; aBus/dBus register bus; wrEnable/rdEnable/frameErr one-clk pulses.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spiSck,
  input  logic              spiCs_n,
  input  logic              spiMosi,
  output logic              spiMiso,
  input  logic [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0] aBus,
  output logic [DATA_W-1:0] dBus,
  output logic              wrEnable,
  output logic              rdEnable,
  output logic              frameErr
);
  localparam int FW = HDR_W + DATA_W;
  localparam int CW = $clog2(FW + 1);
  localparam int SW = DATA_W > HDR_W ? DATA_W : HDR_W;
  logic sck_rise, sck_fall, cs_n, mosi;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sh_q, sh_d, sh_nx;
  logic [DATA_W-1:0] so_q, so_d, dbus_q, dbus_d;
  logic [ADDR_W-1:0] abus_q, abus_d;
  logic rd_q, rd_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;
  spi_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .sck_i     (spiSck),
    .cs_n_i    (spiCs_n),
    .mosi_i    (spiMosi),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall),
    .cs_n_o    (cs_n),
    .mosi_o    (mosi)
  );
  assign sh_nx = {sh_q[SW-2:0], mosi};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      so_q    <= '0;
      dbus_q  <= '0;
      abus_q  <= '0;
      rd_q    <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      dbus_q  <= dbus_d;
      abus_q  <= abus_d;
      rd_q    <= rd_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    abus_d  = abus_q;
    dbus_d  = dbus_q;
    rd_d    = rd_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d   = 1'b0;
    // rdData is sampled while rdEnable is high; the fall after the 8th rise is skipped so bit 7 is held for the 9th rise
    so_d = rd_en_q ? rdData
         : (sck_fall && state_q == DATA && rd_q && cnt_q > CW'(HDR_W)) ? so_q << 1 : so_q;
    case (state_q)
      IDLE: if (!cs_n) begin
        state_d = HDR;
        cnt_d   = '0;
      end
      HDR: if (cs_n) begin
        state_d = IDLE;
        err_d   = 1'b1;
        so_d    = '0;
      end else if (sck_rise) begin
        sh_d  = sh_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(HDR_W - 1)) begin
          abus_d  = sh_nx[ADDR_W-1:0];
          rd_d    = sh_nx[RW_BIT];
          rd_en_d = sh_nx[RW_BIT];
          state_d = DATA;
        end
      end
      DATA: if (cs_n) begin
        state_d = IDLE;
        err_d   = 1'b1;
        so_d    = '0;
      end else if (sck_rise) begin
        sh_d  = sh_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(FW - 1)) begin
          state_d = DONE;
          dbus_d  = rd_q ? dbus_q : sh_nx[DATA_W-1:0];
          wr_en_d = !rd_q;
        end
      end
      DONE: if (cs_n) begin
        state_d = IDLE;
        so_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign spiMiso  = so_q[DATA_W-1];
  assign aBus     = abus_q;
  assign dBus     = dbus_q;
  assign wrEnable = wr_en_q;
  assign rdEnable = rd_en_q;
  assign frameErr = err_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: table-driven self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;
  logic clk = 1'b0;
  logic rst, spiSck, spiCs_n, spiMosi, spiMiso;
  logic [7:0] rdData, dBus;
  logic [3:0] aBus;
  logic wrEnable, rdEnable, frameErr;
  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [3:0] wr_a = '0;
  logic [7:0] wr_d = '0;
  always #5 clk = ~clk;
  assign rdData = (aBus == 4'd3) ? 8'h3C : 8'hE1;
  spi_reg_bridge #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .spiSck(spiSck), .spiCs_n(spiCs_n), .spiMosi(spiMosi),
    .spiMiso(spiMiso), .rdData(rdData), .aBus(aBus), .dBus(dBus),
    .wrEnable(wrEnable), .rdEnable(rdEnable), .frameErr(frameErr)
  );
  always @(negedge clk) begin
    if (wrEnable) begin
      wr_cnt++;
      wr_a = aBus;
      wr_d = dBus;
    end
    if (rdEnable) rd_cnt++;
    if (frameErr) err_cnt++;
    if (wrEnable && rdEnable) both_cnt++;
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic frame(input logic [23:0] bits, input int n, input int gap, input bit close,
                       output logic [7:0] rx);
    rx = '0;
    spiCs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spiMosi = bits[23-i];
      repeat (8) @(negedge clk);
      spiSck = 1'b1;
      if (i >= 8 && i < 16) rx = {rx[6:0], spiMiso};
      repeat (8) @(negedge clk);
      spiSck = 1'b0;
    end
    if (close) begin
      repeat (4) @(negedge clk);
      spiCs_n = 1'b1;
      repeat (gap) @(negedge clk);
    end
  endtask
  typedef struct {
    logic [23:0] bits;
    int n;
    int gap;
    int dwr;
    int drd;
    int derr;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] miso;
    bit chk_miso;
  } vec_t;
  vec_t v[6];
  initial begin
    logic [7:0] rx;
    int w0, r0, e0;
    v[0] = '{24'h05A700, 16, 10, 1, 0, 0, 4'h5, 8'hA7, 8'h00, 1'b0};
    v[1] = '{24'h830000, 16, 10, 0, 1, 0, 4'h3, 8'hA7, 8'h3C, 1'b1};
    v[2] = '{24'h02FF00, 11, 10, 0, 0, 1, 4'h2, 8'hA7, 8'h00, 1'b0};
    v[3] = '{24'h0155AA, 24, 10, 1, 0, 0, 4'h1, 8'h55, 8'h00, 1'b0};
    v[4] = '{24'h061100, 16,  2, 1, 0, 0, 4'h6, 8'h11, 8'h00, 1'b0};
    v[5] = '{24'h072200, 16, 10, 1, 0, 0, 4'h7, 8'h22, 8'h00, 1'b0};
    rst = 1'b1;
    spiCs_n = 1'b1;
    spiSck = 1'b0;
    spiMosi = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_abus", 32'(aBus), 32'h0);
    check("rst_dbus", 32'(dBus), 32'h0);
    check("rst_strobes", {29'h0, wrEnable, rdEnable, frameErr}, 32'h0);
    check("rst_miso", 32'(spiMiso), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt;
      r0 = rd_cnt;
      e0 = err_cnt;
      frame(v[i].bits, v[i].n, v[i].gap, 1'b1, rx);
      check($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt - w0), 32'(v[i].dwr));
      check($sformatf("v%0d_rd_pulses", i), 32'(rd_cnt - r0), 32'(v[i].drd));
      check($sformatf("v%0d_err_pulses", i), 32'(err_cnt - e0), 32'(v[i].derr));
      check($sformatf("v%0d_abus", i), 32'(aBus), 32'(v[i].a));
      check($sformatf("v%0d_dbus", i), 32'(dBus), 32'(v[i].d));
      check($sformatf("v%0d_miso_idle", i), 32'(spiMiso), 32'h0);
      if (v[i].dwr == 1) begin
        check($sformatf("v%0d_abus_at_wr", i), 32'(wr_a), 32'(v[i].a));
        check($sformatf("v%0d_dbus_at_wr", i), 32'(wr_d), 32'(v[i].d));
      end
      if (v[i].chk_miso) check($sformatf("v%0d_miso_byte", i), 32'(rx), 32'(v[i].miso));
    end
    w0 = wr_cnt;
    e0 = err_cnt;
    frame(24'h093300, 12, 0, 1'b0, rx);
    check("pre_rst_abus", 32'(aBus), 32'h9);
    #3 rst = 1'b1;
    #1;
    check("async_rst_abus", 32'(aBus), 32'h0);
    check("async_rst_dbus", 32'(dBus), 32'h0);
    check("async_rst_strobes", {29'h0, wrEnable, rdEnable, frameErr}, 32'h0);
    spiCs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_frame_no_wr", 32'(wr_cnt - w0), 32'h0);
    frame(24'h041100, 16, 10, 1'b1, rx);
    check("post_rst_wr_pulses", 32'(wr_cnt - w0), 32'h1);
    check("post_rst_abus", 32'(aBus), 32'h4);
    check("post_rst_dbus", 32'(dBus), 32'h11);
    check("post_rst_no_err", 32'(err_cnt - e0), 32'h0);
    check("wr_rd_overlap", 32'(both_cnt), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
